usb_tx_controller: RTL and testbench
====================================

Name: usb_tx_controller

Overview:
Transmit-side packet sequencer for the USB device endpoint. On a start request it fetches payload bytes from the TX FIFO and presents them one byte at a time to the NRZI/bit-stuff encoder, in this order: SYNC, PID, data, then the CRC16 trailer. It then requests EOP generation and reports completion. It is the counterpart of the receive controller and drives the same byte-level encoder/shifter datapath.

Parameters:
SYNC_BYTE, 8'h80, sync pattern byte, sent LSB-first on the wire.
MAX_LEN, 64, maximum payload bytes per packet.

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
tx_start  in  1  one-cycle request to send a packet; sampled only in IDLE
tx_pid  in  4  PID nibble; latched on an accepted tx_start
tx_len  in  7  payload byte count, 0..MAX_LEN; latched on an accepted tx_start
fifo_empty  in  1  TX FIFO empty
fifo_rdata  in  8  FIFO read data; valid the cycle after fifo_read
fifo_read  out  1  one-cycle FIFO pop
tx_byte  out  8  byte presented to the encoder
byte_valid  out  1  tx_byte valid; held until byte_taken
byte_taken  in  1  encoder loaded tx_byte into its shifter (one-cycle pulse)
send_eop  out  1  request to the encoder to drive SE0/EOP; held until eop_done
eop_done  in  1  encoder finished EOP (one-cycle pulse)
tx_busy  out  1  high in every state except IDLE
tx_done  out  1  one-cycle pulse: packet completed normally
tx_error  out  1  one-cycle pulse: FIFO underflow abort

Behaviour:
- Reset (async): state IDLE. All outputs 0. CRC register 16'hFFFF. Latched pid/len cleared.
- Packet type:
  - tx_pid[1:0]==2'b11 is a data packet: payload plus CRC16.
  - Any other tx_pid is a token/handshake packet: PID only. tx_len is ignored and treated as 0. No CRC is sent.
- tx_len > MAX_LEN is clamped to MAX_LEN.
- States and transitions:
  - IDLE: on tx_start, latch the pid and the remaining count, set CRC=16'hFFFF, go to SYNC. tx_start in any other state is ignored.
  - SYNC: tx_byte=SYNC_BYTE, byte_valid=1. On byte_taken go to PID.
  - PID: tx_byte={~tx_pid,tx_pid}, byte_valid=1. On byte_taken:
    - non-data packet: go to EOP;
    - data packet with count==0: go to CRC_LO;
    - otherwise: go to FETCH.
  - FETCH: if fifo_empty, pulse tx_error and go to ABORT. Otherwise assert fifo_read for exactly one cycle and go to LOAD.
  - LOAD: register fifo_rdata into tx_byte, go to DATA.
  - DATA: byte_valid=1. On byte_taken, update CRC with tx_byte and decrement the count. If the new count==0 go to CRC_LO, else go to FETCH.
  - CRC_LO: tx_byte=~crc[7:0], byte_valid=1. On byte_taken go to CRC_HI.
  - CRC_HI: tx_byte=~crc[15:8], byte_valid=1. On byte_taken go to EOP.
  - EOP: send_eop=1. On eop_done, pulse tx_done and go to IDLE.
  - ABORT: send_eop=1. This truncates the packet so the host sees a bad CRC. On eop_done go to IDLE; no tx_done is pulsed.
- CRC16:
  - Reflected polynomial 16'hA001, init 16'hFFFF.
  - Byte update is combinational over 8 bit-steps, LSB first, registered on byte_taken in DATA only.
  - SYNC, PID and CRC bytes are excluded from the CRC.
- byte_valid/tx_byte must remain stable from assertion until the cycle byte_taken is sampled high. byte_taken while byte_valid=0 is ignored.
- fifo_read never asserts outside FETCH. There is at most one pop per payload byte.
- No timeout: if byte_taken or eop_done never arrives, the block stays in the current state. Only reset recovers it.
- Reset mid-packet returns to IDLE immediately. Outputs drop to 0 and no tx_done/tx_error pulse is produced.

Test Plan:
- Handshake ACK: tx_start, tx_pid=4'b0010 -> bytes 0x80, 0xD2 in order, then send_eop; tx_done after eop_done; fifo_read never asserted.
- Zero-length DATA0: tx_pid=4'b0011, tx_len=0 -> bytes 0x80, 0xC3, 0x00, 0x00, then EOP and tx_done.
- One-byte DATA1 payload 0x00: tx_pid=4'b1011, tx_len=1 -> bytes 0x80, 0x4B, 0x00, 0x40, 0xBF; exactly one fifo_read.
- 64-byte payload with byte_taken delayed randomly 8-40 cycles -> tx_byte stable while waiting; 64 pops; CRC bytes match the software CRC16 model; tx_len=100 sends 64 bytes.
- Underflow: tx_len=4, FIFO holds 2 bytes -> 2 data bytes sent, tx_error pulses at the third FETCH, send_eop asserted, IDLE after eop_done, no tx_done.
- Reset and start masking: n_rst low during DATA -> all outputs 0 asynchronously, IDLE on release; tx_start pulsed while tx_busy=1 -> ignored, the current packet completes unchanged.

Source files
------------

// File: rtl/usb_tx_controller.sv
// USB transmit packet sequencer.
// Presents SYNC, PID, payload and the CRC16 trailer one byte at a time to the
// NRZI/bit-stuff encoder, then requests EOP. A FIFO underflow mid-payload
// truncates the packet with an EOP so the host discards it on a bad CRC.
module usb_tx_controller #(
    parameter logic [7:0] SYNC_BYTE = 8'h80,
    parameter int         MAX_LEN   = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [3:0] tx_pid,
    input  logic [6:0] tx_len,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_rdata,
    output logic       fifo_read,
    output logic [7:0] tx_byte,
    output logic       byte_valid,
    input  logic       byte_taken,
    output logic       send_eop,
    input  logic       eop_done,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam logic [6:0] LEN_MAX = 7'(MAX_LEN);

    typedef enum logic [3:0] {
        S_IDLE, S_SYNC, S_PID, S_FETCH, S_LOAD,
        S_DATA, S_CRC_LO, S_CRC_HI, S_EOP, S_ABORT
    } state_t;

    state_t      r_state, w_next;
    logic [3:0]  r_pid;
    logic [6:0]  r_cnt;
    logic [15:0] r_crc;
    logic [7:0]  r_data;

    logic        w_is_data;
    logic        w_start_data;
    logic [6:0]  w_len_clamp;
    logic [15:0] w_crc_next;

    // One byte of reflected CRC16 (poly 0xA001), LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] v;
        v = c;
        for (int i = 0; i < 8; i++) begin
            if (v[0] ^ d[i]) v = (v >> 1) ^ 16'hA001;
            else             v = v >> 1;
        end
        return v;
    endfunction

    assign w_is_data    = (r_pid[1:0] == 2'b11);
    assign w_start_data = (tx_pid[1:0] == 2'b11);
    assign w_len_clamp  = (tx_len > LEN_MAX) ? LEN_MAX : tx_len;
    assign w_crc_next   = crc16_byte(r_crc, r_data);

    // State register; async reset drops the sequencer straight back to IDLE.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Packet context: latched PID, remaining count, running CRC, payload byte.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_pid  <= '0;
            r_cnt  <= '0;
            r_crc  <= 16'hFFFF;
            r_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (tx_start) begin
                    r_pid <= tx_pid;
                    // Tokens and handshakes carry no payload whatever tx_len says.
                    r_cnt <= w_start_data ? w_len_clamp : 7'd0;
                    r_crc <= 16'hFFFF;
                end
                S_LOAD: r_data <= fifo_rdata;
                S_DATA: if (byte_taken) begin
                    r_crc <= w_crc_next;
                    r_cnt <= r_cnt - 7'd1;
                end
                default: ;
            endcase
        end
    end

    // Next-state and output decode; byte outputs are pure functions of state
    // and registered context, so they stay stable until byte_taken.
    always_comb begin
        w_next     = r_state;
        fifo_read  = 1'b0;
        tx_byte    = 8'h00;
        byte_valid = 1'b0;
        send_eop   = 1'b0;
        tx_busy    = (r_state != S_IDLE);
        tx_done    = 1'b0;
        tx_error   = 1'b0;
        case (r_state)
            S_IDLE: if (tx_start) w_next = S_SYNC;
            S_SYNC: begin
                tx_byte    = SYNC_BYTE;
                byte_valid = 1'b1;
                if (byte_taken) w_next = S_PID;
            end
            S_PID: begin
                tx_byte    = {~r_pid, r_pid};
                byte_valid = 1'b1;
                if (byte_taken) begin
                    if (!w_is_data)         w_next = S_EOP;
                    else if (r_cnt == 7'd0) w_next = S_CRC_LO;
                    else                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (fifo_empty) begin
                    tx_error = 1'b1;
                    w_next   = S_ABORT;
                end else begin
                    fifo_read = 1'b1;
                    w_next    = S_LOAD;
                end
            end
            S_LOAD: w_next = S_DATA;
            S_DATA: begin
                tx_byte    = r_data;
                byte_valid = 1'b1;
                if (byte_taken) w_next = (r_cnt == 7'd1) ? S_CRC_LO : S_FETCH;
            end
            S_CRC_LO: begin
                tx_byte    = ~r_crc[7:0];
                byte_valid = 1'b1;
                if (byte_taken) w_next = S_CRC_HI;
            end
            S_CRC_HI: begin
                tx_byte    = ~r_crc[15:8];
                byte_valid = 1'b1;
                if (byte_taken) w_next = S_EOP;
            end
            S_EOP: begin
                send_eop = 1'b1;
                if (eop_done) begin
                    tx_done = 1'b1;
                    w_next  = S_IDLE;
                end
            end
            S_ABORT: begin
                send_eop = 1'b1;
                if (eop_done) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_usb_tx_controller.sv
// Directed bench for usb_tx_controller: expected wire bytes are queued when a
// packet is launched and popped as the modelled encoder accepts each byte.
module tb_usb_tx_controller;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       tx_start = 1'b0;
    logic [3:0] tx_pid = '0;
    logic [6:0] tx_len = '0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_rdata = '0;
    logic       fifo_read;
    logic [7:0] tx_byte;
    logic       byte_valid;
    logic       byte_taken = 1'b0;
    logic       send_eop;
    logic       eop_done = 1'b0;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    int total = 0, bad = 0;
    int pops = 0, done_cnt = 0, err_cnt = 0;
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];

    usb_tx_controller dut (
        .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .tx_pid(tx_pid), .tx_len(tx_len),
        .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_read(fifo_read),
        .tx_byte(tx_byte), .byte_valid(byte_valid), .byte_taken(byte_taken),
        .send_eop(send_eop), .eop_done(eop_done), .tx_busy(tx_busy),
        .tx_done(tx_done), .tx_error(tx_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Software CRC16: reflected 0xA001, init 0xFFFF, result as sent (inverted).
    function automatic logic [15:0] crc_model(input logic [7:0] b[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (b[k]) begin
            c = c ^ {8'h00, b[k]};
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return ~c;
    endfunction

    // FIFO model and pulse counters, sampled just after the falling edge.
    initial begin
        forever begin
            @(negedge clk); #1;
            fifo_empty = (fifo_q.size() == 0);
            if (tx_done)  done_cnt++;
            if (tx_error) err_cnt++;
            if (fifo_read) begin
                @(posedge clk); #1;
                if (fifo_q.size() > 0) fifo_rdata = fifo_q.pop_front();
                else                   fifo_rdata = 8'hEE;
                pops++;
                fifo_empty = (fifo_q.size() == 0);
            end
        end
    end

    task automatic start(input logic [3:0] pid, input logic [6:0] len);
        @(negedge clk);
        tx_pid = pid; tx_len = len; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    // Encoder model: wait for a valid byte, hold off for a random delay while
    // checking stability, then accept it and compare against the scoreboard.
    task automatic take_bytes(input int n, input int dmin, input int dmax);
        int w, d;
        logic [7:0] held, e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            w = 0;
            while (!byte_valid && w < 200) begin @(negedge clk); w++; end
            if (w >= 200) begin chk("byte_wait_timeout", 32'd0, 32'd1); return; end
            held = tx_byte;
            d = $urandom_range(dmax, dmin);
            repeat (d) begin
                @(negedge clk);
                chk("hold_valid", {31'd0, byte_valid}, 32'd1);
                chk("hold_byte", {24'd0, tx_byte}, {24'd0, held});
            end
            if (exp_q.size() == 0) begin chk("scoreboard_empty", 32'd0, 32'd1); return; end
            e = exp_q.pop_front();
            chk("byte", {24'd0, tx_byte}, {24'd0, e});
            byte_taken = 1'b1;
            @(negedge clk);
            byte_taken = 1'b0;
        end
    endtask

    task automatic finish_eop(input logic exp_done);
        int w, d0;
        @(negedge clk);
        w = 0;
        while (!send_eop && w < 200) begin @(negedge clk); w++; end
        if (w >= 200) begin chk("eop_wait_timeout", 32'd0, 32'd1); return; end
        chk("eop_busy", {31'd0, tx_busy}, 32'd1);
        chk("eop_no_valid", {31'd0, byte_valid}, 32'd0);
        repeat (2) @(negedge clk);
        chk("eop_held", {31'd0, send_eop}, 32'd1);
        d0 = done_cnt;
        eop_done = 1'b1;
        #1 chk("tx_done", {31'd0, tx_done}, {31'd0, exp_done});
        @(negedge clk);
        eop_done = 1'b0;
        #2;
        chk("idle_after_eop", {31'd0, tx_busy}, 32'd0);
        chk("done_count", done_cnt - d0, {31'd0, exp_done});
    endtask

    initial begin
        int p0, e0, d0, w;
        logic [7:0] pay[$];
        logic [15:0] crc;

        // Reset state
        #1;
        chk("rst_busy", {31'd0, tx_busy}, 32'd0);
        chk("rst_valid", {31'd0, byte_valid}, 32'd0);
        chk("rst_byte", {24'd0, tx_byte}, 32'd0);
        chk("rst_outs", {28'd0, fifo_read, send_eop, tx_done, tx_error}, 32'd0);
        #22 n_rst = 1'b1;

        // ACK handshake: PID only, no FIFO traffic
        exp_q = '{8'h80, 8'hD2};
        p0 = pops;
        start(4'b0010, 7'd5);
        take_bytes(2, 0, 3);
        finish_eop(1'b1);
        chk("ack_pops", pops - p0, 32'd0);

        // Zero-length DATA0, with a stray tx_start while busy that must be ignored
        exp_q = '{8'h80, 8'hC3, 8'h00, 8'h00};
        p0 = pops;
        start(4'b0011, 7'd0);
        chk("busy_after_start", {31'd0, tx_busy}, 32'd1);
        tx_pid = 4'b1011; tx_len = 7'd9; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        take_bytes(4, 0, 2);
        finish_eop(1'b1);
        chk("zlp_pops", pops - p0, 32'd0);

        // One-byte DATA1 payload 0x00
        fifo_q = '{8'h00};
        exp_q = '{8'h80, 8'h4B, 8'h00, 8'h40, 8'hBF};
        p0 = pops;
        start(4'b1011, 7'd1);
        take_bytes(5, 0, 3);
        finish_eop(1'b1);
        chk("one_pops", pops - p0, 32'd1);

        // Short DATA0 with random payload, fast encoder
        pay.delete();
        for (int i = 0; i < 5; i++) pay.push_back(8'($urandom));
        crc = crc_model(pay);
        fifo_q = pay;
        exp_q = '{8'h80, 8'hC3};
        foreach (pay[i]) exp_q.push_back(pay[i]);
        exp_q.push_back(crc[7:0]); exp_q.push_back(crc[15:8]);
        p0 = pops;
        start(4'b0011, 7'd5);
        take_bytes(9, 0, 1);
        finish_eop(1'b1);
        chk("short_pops", pops - p0, 32'd5);

        // Max-length DATA1 requested as 100 bytes, slow encoder
        pay.delete();
        for (int i = 0; i < 64; i++) pay.push_back(8'($urandom));
        crc = crc_model(pay);
        fifo_q = pay;
        exp_q = '{8'h80, 8'h4B};
        foreach (pay[i]) exp_q.push_back(pay[i]);
        exp_q.push_back(crc[7:0]); exp_q.push_back(crc[15:8]);
        p0 = pops;
        start(4'b1011, 7'd100);
        take_bytes(68, 8, 40);
        finish_eop(1'b1);
        chk("max_pops", pops - p0, 32'd64);
        chk("max_sb_drained", exp_q.size(), 32'd0);

        // Underflow: 4 requested, 2 available
        fifo_q = '{8'h5A, 8'hA5};
        exp_q = '{8'h80, 8'hC3, 8'h5A, 8'hA5};
        p0 = pops; e0 = err_cnt;
        start(4'b0011, 7'd4);
        take_bytes(4, 0, 2);
        finish_eop(1'b0);
        chk("uf_err_pulse", err_cnt - e0, 32'd1);
        chk("uf_pops", pops - p0, 32'd2);

        // Reset in the middle of DATA
        fifo_q = '{8'h11, 8'h22, 8'h33};
        exp_q = '{8'h80, 8'hC3};
        d0 = done_cnt; e0 = err_cnt;
        start(4'b0011, 7'd3);
        take_bytes(2, 0, 1);
        w = 0;
        while (!byte_valid && w < 50) begin @(negedge clk); w++; end
        chk("mid_reach_data", {24'd0, tx_byte}, 32'h11);
        #2 n_rst = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, tx_busy}, 32'd0);
        chk("mid_rst_valid", {31'd0, byte_valid}, 32'd0);
        chk("mid_rst_byte", {24'd0, tx_byte}, 32'd0);
        chk("mid_rst_outs", {28'd0, fifo_read, send_eop, tx_done, tx_error}, 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        fifo_q.delete();
        repeat (3) @(negedge clk);
        chk("mid_idle", {31'd0, tx_busy}, 32'd0);
        chk("mid_no_pulses", (done_cnt - d0) + (err_cnt - e0), 32'd0);

        // Recovery: a normal handshake after reset
        exp_q = '{8'h80, 8'h5A};
        start(4'b1010, 7'd0);
        take_bytes(2, 0, 2);
        finish_eop(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
